// File: rtl/wb_intercon_mux_if.sv
// Wishbone single-master / N-slave bundle seen by the address-decode mux.
// The slave modport is the mux's own view; the master modport is the surrounding fabric.
interface wb_intercon_mux_if #(
  parameter int dw         = 32,
  parameter int aw         = 32,
  parameter int num_slaves = 2
);
  logic [aw-1:0]                  wbm_adr_i;
  logic [dw-1:0]                  wbm_dat_i;
  logic [dw/8-1:0]                wbm_sel_i;
  logic                           wbm_we_i;
  logic                           wbm_cyc_i;
  logic                           wbm_stb_i;
  logic [2:0]                     wbm_cti_i;
  logic [1:0]                     wbm_bte_i;
  logic [dw-1:0]                  wbm_dat_o;
  logic                           wbm_ack_o;
  logic                           wbm_err_o;
  logic                           wbm_rty_o;

  logic [num_slaves*aw-1:0]       wbs_adr_o;
  logic [num_slaves*dw-1:0]       wbs_dat_o;
  logic [num_slaves*(dw/8)-1:0]   wbs_sel_o;
  logic [num_slaves-1:0]          wbs_we_o;
  logic [num_slaves-1:0]          wbs_cyc_o;
  logic [num_slaves-1:0]          wbs_stb_o;
  logic [num_slaves*3-1:0]        wbs_cti_o;
  logic [num_slaves*2-1:0]        wbs_bte_o;
  logic [num_slaves*dw-1:0]       wbs_dat_i;
  logic [num_slaves-1:0]          wbs_ack_i;
  logic [num_slaves-1:0]          wbs_err_i;
  logic [num_slaves-1:0]          wbs_rty_i;

  modport slave (
    input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
    output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o,
    input  wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
  );

  modport master (
    output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
    input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o,
    output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
  );
endinterface

// File: rtl/wb_intercon_mux.sv
// Wishbone B3 single-master to N-slave address-decode mux: combinational steering,
// lowest-index priority on overlapping windows, registered decode-error pulse.

module wb_intercon_mux_lane #(
  parameter int dw = 32
) (
  input  logic          i_match,
  input  logic          i_lower_hit,
  input  logic          i_cyc,
  input  logic [dw-1:0] i_dat,
  input  logic          i_ack,
  input  logic          i_err,
  input  logic          i_rty,
  output logic          o_cyc,
  output logic [dw-1:0] o_dat,
  output logic          o_ack,
  output logic          o_err,
  output logic          o_rty
);
  logic w_grant;

  // A lower-indexed hit shadows this lane, so at most one lane ever owns the bus.
  assign w_grant = i_match & ~i_lower_hit;
  assign o_cyc   = i_cyc & w_grant;
  assign o_dat   = w_grant ? i_dat : '0;
  assign o_ack   = w_grant & i_ack;
  assign o_err   = w_grant & i_err;
  assign o_rty   = w_grant & i_rty;
endmodule

module wb_intercon_mux #(
  parameter int                      dw         = 32,
  parameter int                      aw         = 32,
  parameter int                      num_slaves = 2,
  parameter logic [num_slaves*aw-1:0] MATCH_ADDR = '0,
  parameter logic [num_slaves*aw-1:0] MATCH_MASK = '0
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  wb_intercon_mux_if.slave  bus
);
  logic [num_slaves-1:0]         w_match;
  logic [num_slaves-1:0]         w_lower;
  logic [num_slaves-1:0][dw-1:0] w_dat;
  logic [num_slaves-1:0]         w_ack;
  logic [num_slaves-1:0]         w_err;
  logic [num_slaves-1:0]         w_rty;
  logic [dw-1:0]                 w_dat_or;
  logic                          w_hit;
  logic                          r_err;

  for (genvar i = 0; i < num_slaves; i++) begin : g_dec
    localparam logic [aw-1:0] LADDR = MATCH_ADDR[i*aw +: aw];
    localparam logic [aw-1:0] LMASK = MATCH_MASK[i*aw +: aw];
    assign w_match[i] = ((bus.wbm_adr_i & LMASK) == LADDR);
  end

  always_comb begin
    w_lower = '0;
    for (int i = 1; i < num_slaves; i++) w_lower[i] = w_lower[i-1] | w_match[i-1];
  end

  assign w_hit = |w_match;

  for (genvar i = 0; i < num_slaves; i++) begin : g_lane
    wb_intercon_mux_lane #(.dw(dw)) u_lane (
      .i_match     (w_match[i]),
      .i_lower_hit (w_lower[i]),
      .i_cyc       (bus.wbm_cyc_i),
      .i_dat       (bus.wbs_dat_i[i*dw +: dw]),
      .i_ack       (bus.wbs_ack_i[i]),
      .i_err       (bus.wbs_err_i[i]),
      .i_rty       (bus.wbs_rty_i[i]),
      .o_cyc       (bus.wbs_cyc_o[i]),
      .o_dat       (w_dat[i]),
      .o_ack       (w_ack[i]),
      .o_err       (w_err[i]),
      .o_rty       (w_rty[i])
    );
  end

  // Everything but CYC is broadcast; only the granted slave sees a live cycle.
  assign bus.wbs_adr_o = {num_slaves{bus.wbm_adr_i}};
  assign bus.wbs_dat_o = {num_slaves{bus.wbm_dat_i}};
  assign bus.wbs_sel_o = {num_slaves{bus.wbm_sel_i}};
  assign bus.wbs_we_o  = {num_slaves{bus.wbm_we_i}};
  assign bus.wbs_stb_o = {num_slaves{bus.wbm_stb_i}};
  assign bus.wbs_cti_o = {num_slaves{bus.wbm_cti_i}};
  assign bus.wbs_bte_o = {num_slaves{bus.wbm_bte_i}};

  always_comb begin
    w_dat_or = '0;
    for (int i = 0; i < num_slaves; i++) w_dat_or = w_dat_or | w_dat[i];
  end

  assign bus.wbm_dat_o = w_dat_or;
  assign bus.wbm_ack_o = |w_ack;
  assign bus.wbm_rty_o = |w_rty;
  assign bus.wbm_err_o = r_err | (|w_err);

  // Self-clearing so a master that keeps strobing a hole sees ERR every other cycle.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) r_err <= 1'b0;
    else           r_err <= bus.wbm_cyc_i & bus.wbm_stb_i & ~w_hit & ~r_err;
  end
endmodule

// File: tb/tb_wb_intercon_mux.sv
// Directed bench for wb_intercon_mux: four 256-byte memory slaves plus an overlap-configured second instance.
module tb_wb_intercon_mux;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NS = 4;
  localparam logic [NS*AW-1:0] ADDRS    = {32'h300, 32'h200, 32'h100, 32'h000};
  localparam logic [NS*AW-1:0] MASKS    = {4{32'hFFFF_FF00}};
  localparam logic [NS*AW-1:0] ADDRS_OV = {32'h300, 32'h200, 32'h000, 32'h000};
  localparam logic [NS*AW-1:0] MASKS_OV = {32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FE00, 32'hFFFF_FF00};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  wb_intercon_mux_if #(.dw(DW), .aw(AW), .num_slaves(NS)) bus ();
  wb_intercon_mux_if #(.dw(DW), .aw(AW), .num_slaves(NS)) bus2 ();

  wb_intercon_mux #(.dw(DW), .aw(AW), .num_slaves(NS), .MATCH_ADDR(ADDRS), .MATCH_MASK(MASKS)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .bus      (bus.slave)
  );

  wb_intercon_mux #(.dw(DW), .aw(AW), .num_slaves(NS), .MATCH_ADDR(ADDRS_OV), .MATCH_MASK(MASKS_OV)) dut_ov (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .bus      (bus2.slave)
  );

  // Memory slaves: registered ACK one clock after a strobe, one word per beat.
  logic [31:0]   mem [NS][64];
  logic [NS-1:0] s_ack = '0;
  logic [31:0]   s_dat [NS];
  int            wr_cnt [NS];

  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      s_ack[i] <= 1'b0;
      if (bus.wbs_cyc_o[i] && bus.wbs_stb_o[i] && !s_ack[i]) begin
        s_ack[i] <= 1'b1;
        s_dat[i] <= mem[i][bus.wbs_adr_o[i*AW+2 +: 6]];
        if (bus.wbs_we_o[i]) begin
          mem[i][bus.wbs_adr_o[i*AW+2 +: 6]] <= bus.wbs_dat_o[i*DW +: DW];
          wr_cnt[i] <= wr_cnt[i] + 1;
        end
      end
    end
  end

  for (genvar g = 0; g < NS; g++) begin : g_rd
    assign bus.wbs_dat_i[g*DW +: DW] = s_dat[g];
  end
  assign bus.wbs_ack_i  = s_ack;
  assign bus.wbs_rty_i  = '0;
  assign bus2.wbs_dat_i = '0;
  assign bus2.wbs_ack_i = '0;
  assign bus2.wbs_err_i = '0;
  assign bus2.wbs_rty_i = '0;

  task automatic drive(input logic [31:0] a, input logic we, input logic [31:0] d, input logic [2:0] cti);
    bus.wbm_adr_i = a;
    bus.wbm_we_i  = we;
    bus.wbm_dat_i = d;
    bus.wbm_cti_i = cti;
    bus.wbm_bte_i = 2'b00;
    bus.wbm_sel_i = 4'hF;
    bus.wbm_cyc_i = 1'b1;
    bus.wbm_stb_i = 1'b1;
  endtask

  task automatic idle();
    bus.wbm_cyc_i = 1'b0;
    bus.wbm_stb_i = 1'b0;
    bus.wbm_we_i  = 1'b0;
    @(negedge clk);
  endtask

  // Called at (or just after) a falling edge; returns at the falling edge where ACK is seen.
  task automatic xfer(input logic [31:0] a, input logic we, input logic [31:0] d, input logic [2:0] cti,
                      output logic [31:0] rd, output logic got, output logic erred);
    drive(a, we, d, cti);
    got = 1'b0;
    erred = 1'b0;
    rd = '0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (bus.wbm_err_o) erred = 1'b1;
      if (bus.wbm_ack_o) begin
        got = 1'b1;
        rd  = bus.wbm_dat_o;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.wbs_err_i = '0;
    idle();
    total++; if (bus.wbm_err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus.wbm_err_o); end
    total++; if (bus.wbs_cyc_o !== 4'b0000) begin bad++; $display("FAIL reset_cyc got=%b want=0000", bus.wbs_cyc_o); end
    total++; if (bus.wbm_ack_o !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b want=0", bus.wbm_ack_o); end
    drive(32'h104, 1'b0, 32'h0, 3'b000);
    #1;
    total++; if (bus.wbs_cyc_o !== 4'b0010) begin bad++; $display("FAIL reset_comb_cyc got=%b want=0010", bus.wbs_cyc_o); end
    idle();
    idle();
    rst_n = 1'b1;
    idle();
  endtask

  task automatic test_single();
    logic [31:0] rd;
    logic got, erred;
    int c1;
    c1 = wr_cnt[1];
    drive(32'h104, 1'b1, 32'hDEAD_BEEF, 3'b000);
    #1;
    total++; if (bus.wbs_cyc_o !== 4'b0010) begin bad++; $display("FAIL single_cyc got=%b want=0010", bus.wbs_cyc_o); end
    xfer(32'h104, 1'b1, 32'hDEAD_BEEF, 3'b000, rd, got, erred);
    total++; if (got !== 1'b1) begin bad++; $display("FAIL single_wr_ack got=%b want=1", got); end
    total++; if (wr_cnt[1] !== c1 + 1) begin bad++; $display("FAIL single_slave1_writes got=%0d want=%0d", wr_cnt[1], c1 + 1); end
    idle();
    xfer(32'h104, 1'b0, 32'h0, 3'b000, rd, got, erred);
    total++; if (got !== 1'b1) begin bad++; $display("FAIL single_rd_ack got=%b want=1", got); end
    total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_rd_data got=%h want=deadbeef", rd); end
    idle();
  endtask

  task automatic test_decode();
    logic [31:0] adrs [4] = '{32'h000, 32'h1FC, 32'h200, 32'h3FC};
    logic [31:0] dats [4] = '{32'h1111_0000, 32'h2222_01FC, 32'h3333_0200, 32'h4444_03FC};
    logic [3:0]  cycs [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [31:0] rd;
    logic got, erred;
    for (int k = 0; k < 4; k++) begin
      drive(adrs[k], 1'b1, dats[k], 3'b000);
      #1;
      total++; if (bus.wbs_cyc_o !== cycs[k]) begin bad++; $display("FAIL decode_cyc[%0d] got=%b want=%b", k, bus.wbs_cyc_o, cycs[k]); end
      xfer(adrs[k], 1'b1, dats[k], 3'b000, rd, got, erred);
      total++; if (got !== 1'b1) begin bad++; $display("FAIL decode_wr_ack[%0d] got=%b want=1", k, got); end
      idle();
    end
    for (int k = 0; k < 4; k++) begin
      xfer(adrs[k], 1'b0, 32'h0, 3'b000, rd, got, erred);
      total++; if (rd !== dats[k] || got !== 1'b1) begin bad++; $display("FAIL decode_rd[%0d] got=%h ack=%b want=%h", k, rd, got, dats[k]); end
      idle();
    end
  endtask

  task automatic test_nomatch();
    drive(32'h400, 1'b0, 32'h0, 3'b000);
    #1;
    total++; if (bus.wbs_cyc_o !== 4'b0000) begin bad++; $display("FAIL nomatch_cyc got=%b want=0000", bus.wbs_cyc_o); end
    total++; if (bus.wbm_err_o !== 1'b0) begin bad++; $display("FAIL nomatch_err_early got=%b want=0", bus.wbm_err_o); end
    total++; if (bus.wbm_dat_o !== 32'h0) begin bad++; $display("FAIL nomatch_dat got=%h want=0", bus.wbm_dat_o); end
    @(negedge clk);
    total++; if (bus.wbm_err_o !== 1'b1) begin bad++; $display("FAIL nomatch_err_pulse got=%b want=1", bus.wbm_err_o); end
    total++; if (bus.wbm_ack_o !== 1'b0) begin bad++; $display("FAIL nomatch_ack got=%b want=0", bus.wbm_ack_o); end
    @(negedge clk);
    total++; if (bus.wbm_err_o !== 1'b0) begin bad++; $display("FAIL nomatch_err_gap got=%b want=0", bus.wbm_err_o); end
    @(negedge clk);
    total++; if (bus.wbm_err_o !== 1'b1) begin bad++; $display("FAIL nomatch_err_refire got=%b want=1", bus.wbm_err_o); end
    idle();
    total++; if (bus.wbm_err_o !== 1'b0) begin bad++; $display("FAIL nomatch_err_after got=%b want=0", bus.wbm_err_o); end
    idle();
  endtask

  task automatic test_overlap();
    logic [31:0] adrs [3] = '{32'h080, 32'h180, 32'h280};
    logic [3:0]  cycs [3] = '{4'b0001, 4'b0010, 4'b0100};
    bus2.wbm_cyc_i = 1'b1;
    bus2.wbm_stb_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus2.wbm_adr_i = adrs[k];
      #1;
      total++; if (bus2.wbs_cyc_o !== cycs[k]) begin bad++; $display("FAIL overlap_cyc[%0d] got=%b want=%b", k, bus2.wbs_cyc_o, cycs[k]); end
    end
    bus2.wbm_cyc_i = 1'b0;
    bus2.wbm_stb_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    drive(32'h400, 1'b0, 32'h0, 3'b000);
    @(negedge clk);
    total++; if (bus.wbm_err_o !== 1'b1) begin bad++; $display("FAIL rstmid_pending got=%b want=1", bus.wbm_err_o); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.wbm_err_o !== 1'b0) begin bad++; $display("FAIL rstmid_clear got=%b want=0", bus.wbm_err_o); end
    @(negedge clk);
    total++; if (bus.wbm_err_o !== 1'b0) begin bad++; $display("FAIL rstmid_held got=%b want=0", bus.wbm_err_o); end
    rst_n = 1'b1;
    #1;
    total++; if (bus.wbm_err_o !== 1'b0) begin bad++; $display("FAIL rstmid_release got=%b want=0", bus.wbm_err_o); end
    @(negedge clk);
    total++; if (bus.wbm_err_o !== 1'b1) begin bad++; $display("FAIL rstmid_after got=%b want=1", bus.wbm_err_o); end
    idle();
    idle();
  endtask

  task automatic test_slave_err();
    bus.wbs_err_i = 4'b0100;
    drive(32'h208, 1'b0, 32'h0, 3'b000);
    #1;
    total++; if (bus.wbm_err_o !== 1'b1) begin bad++; $display("FAIL slverr_sel got=%b want=1", bus.wbm_err_o); end
    bus.wbm_adr_i = 32'h108;
    #1;
    total++; if (bus.wbm_err_o !== 1'b0) begin bad++; $display("FAIL slverr_other got=%b want=0", bus.wbm_err_o); end
    bus.wbs_err_i = '0;
    idle();
    idle();
  endtask

  task automatic test_random();
    logic [31:0] shadow [256];
    bit          valid [256];
    int          base [NS];
    int          nwr = 0, nerr = 0, nto = 0, sum = 0;
    logic [31:0] rd, d;
    logic        got, erred, we;
    int          w, beats;
    for (int i = 0; i < 256; i++) valid[i] = 1'b0;
    for (int i = 0; i < NS; i++) base[i] = wr_cnt[i];
    for (int t = 0; t < 1000; t++) begin
      w = $urandom_range(0, 255);
      if ($urandom_range(0, 3) == 0) begin
        w = w & ~3;
        beats = 4;
        we = 1'b1;
      end else begin
        beats = 1;
        we = 1'($urandom_range(0, 1));
      end
      for (int b = 0; b < beats; b++) begin
        d = $urandom;
        xfer(32'((w + b) * 4), we, d, (beats == 1) ? 3'b000 : ((b == beats - 1) ? 3'b111 : 3'b010), rd, got, erred);
        if (!got) nto++;
        if (erred) nerr++;
        if (we) begin
          nwr++;
          shadow[w + b] = d;
          valid[w + b] = 1'b1;
        end else if (valid[w + b]) begin
          total++; if (rd !== shadow[w + b]) begin bad++; $display("FAIL rand_rd adr=%h got=%h want=%h", (w + b) * 4, rd, shadow[w + b]); end
        end
      end
      idle();
    end
    for (int i = 0; i < NS; i++) sum += wr_cnt[i] - base[i];
    total++; if (sum !== nwr) begin bad++; $display("FAIL rand_write_sum got=%0d want=%0d", sum, nwr); end
    total++; if (nerr !== 0) begin bad++; $display("FAIL rand_spurious_err got=%0d want=0", nerr); end
    total++; if (nto !== 0) begin bad++; $display("FAIL rand_timeouts got=%0d want=0", nto); end
  endtask

  initial begin
    bus.wbm_adr_i = '0; bus.wbm_dat_i = '0; bus.wbm_sel_i = '0; bus.wbm_we_i = 1'b0;
    bus.wbm_cyc_i = 1'b0; bus.wbm_stb_i = 1'b0; bus.wbm_cti_i = '0; bus.wbm_bte_i = '0;
    bus.wbs_err_i = '0;
    bus2.wbm_adr_i = '0; bus2.wbm_dat_i = '0; bus2.wbm_sel_i = '0; bus2.wbm_we_i = 1'b0;
    bus2.wbm_cyc_i = 1'b0; bus2.wbm_stb_i = 1'b0; bus2.wbm_cti_i = '0; bus2.wbm_bte_i = '0;
    test_reset();
    test_single();
    test_decode();
    test_nomatch();
    test_overlap();
    test_reset_mid();
    test_slave_err();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
